da_lut_sequencer: RTL and testbench
===================================

DA_LUT_SEQUENCER -- requirements
Module: da_lut_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH_A, default 8, activation width (bit-planes per operation, N).
REQ-002 SHALL have parameter DATA_WIDTH_B, default 8, weight width.
REQ-003 SHALL have parameter K, default 4, products per dot; multiple of 4, >=4.
REQ-004 SHALL have parameter LUT_WIDTH, default DATA_WIDTH_B+$clog2(K); LUT_out is LUT_WIDTH+1 bits signed.
REQ-005 SHALL have parameter ACC_WIDTH, default LUT_WIDTH+DATA_WIDTH_A+2, result width.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 in_valid  input  1  operand set A_in/B_in valid.
REQ-009 in_ready  output  1  sequencer accepts operands.
REQ-010 A_in  input  K x DATA_WIDTH_A signed  activations.
REQ-011 B_in  input  K x DATA_WIDTH_B signed  weights.
REQ-012 gen_done  output  1  LUT enable; high only while a bit-plane is evaluated.
REQ-013 addr_array  output  K-1  offset-binary LUT address for current plane.
REQ-014 B_temp  output  K x DATA_WIDTH_B signed  registered weights to LUT.
REQ-015 LUT_out  input  LUT_WIDTH+1 signed  combinational LUT result, same cycle as address.
REQ-016 out_valid / out_ready  output / input  1 each  result handshake.
REQ-017 result  output  ACC_WIDTH signed  dot product; busy  output  1  high when not IDLE.

Function
REQ-018 States IDLE, RUN, FIX, DONE; in_ready=1 only in IDLE.
REQ-019 IDLE: in_valid&in_ready edge captures A_in, B_in, clears acc, sets bit_idx=N-1, -> RUN.
REQ-020 RUN, per cycle, plane j=bit_idx: b0=A[0][j]; addr_array[k-1]=A[k][j] XNOR b0 for k=1..K-1; s=+1 if b0 else -1.
REQ-021 RUN update: acc <= 2*acc + t, t = -s*LUT_out for j=N-1 (sign plane), t = +s*LUT_out otherwise; sign-extended, no saturation.
REQ-022 RUN: bit_idx decrements; edge with bit_idx=0 -> FIX; exactly N RUN cycles.
REQ-023 FIX: result <= acc - Q, Q = sum over k of (B[k]>>>1) sign-extended; -> DONE, out_valid=1.
REQ-024 Result SHALL equal sum over k of A[k]*2*(B[k]>>>1) exactly (equals true dot product for even weights).
REQ-025 Latency: out_valid high after N+1 rising edges following accept edge (9 for N=8).
REQ-026 DONE: result, out_valid held stable until out_valid&out_ready edge -> IDLE; out_ready ignored outside DONE.
REQ-027 New operands not accepted before DONE handshake completes; in_valid ignored while busy.
REQ-028 gen_done=0, addr_array=0 outside RUN; B_temp driven from captured B at all times.

Reset
REQ-029 rst low, any state incl. mid-RUN: immediately state=IDLE, acc=0, bit_idx=0, result=0, out_valid=0, gen_done=0, addr_array=0, B registers=0; in_ready=1 after release.
REQ-030 First accept possible on first rising edge with rst high and in_valid high.

Structure
REQ-031 Shared package da_pkg SHALL hold state enum type and ACC_WIDTH/LUT_WIDTH width helper functions.
REQ-032 Combinational sub-module da_plane_addr SHALL form addr_array and s from captured A and bit_idx.
REQ-033 LUT instance is external; sequencer only drives/consumes its ports.

Verification
REQ-034 K=4,N=8: A={1,0,0,0}, B={4,6,8,10} -> result 4, out_valid after 9 edges.
REQ-035 A={-128,127,1,-1}, B={2,2,2,2} -> result -2 (sign-plane negation exercised).
REQ-036 A={1,1,1,1}, B={3,-3,5,7} -> result 8 (halved-weight rule).
REQ-037 out_ready held low 5 cycles in DONE -> result stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-038 rst pulsed low at 4th RUN cycle -> outputs zero immediately; next operation A={2,0,0,0},B={6,0,0,0} -> 12.
REQ-039 Back-to-back: second in_valid held high -> accepted first IDLE cycle after handshake; gen_done high exactly 8 cycles per operation.

Source files
------------

// File: rtl/da_lut_sequencer_pkg.sv
// Shared definitions for the distributed-arithmetic LUT sequencer:
// the FSM state type and the width helpers used for parameter defaults.
package da_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // LUT result magnitude width: one weight plus growth from summing K of them.
  function automatic int lut_width(input int dwb, input int k);
    return dwb + $clog2(k);
  endfunction

  // Accumulator/result width: LUT value shifted across N planes plus headroom.
  function automatic int acc_width(input int lw, input int dwa);
    return lw + dwa + 2;
  endfunction

  // Width of the bit-plane index; never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/da_lut_sequencer_if.sv
// Operand/result handshake bundle between a producer/consumer and the sequencer.
interface da_lut_sequencer_if
  import da_pkg::*;
#(
  parameter int DATA_WIDTH_A = 8,
  parameter int DATA_WIDTH_B = 8,
  parameter int K            = 4,
  parameter int ACC_WIDTH    = acc_width(lut_width(DATA_WIDTH_B, K), DATA_WIDTH_A)
) ();

  logic                                 in_valid;
  logic                                 in_ready;
  logic [K-1:0][DATA_WIDTH_A-1:0]       A_in;
  logic [K-1:0][DATA_WIDTH_B-1:0]       B_in;
  logic                                 out_valid;
  logic                                 out_ready;
  logic signed [ACC_WIDTH-1:0]          result;

  modport master (
    output in_valid, A_in, B_in, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, A_in, B_in, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/da_lut_sequencer_plane_addr.sv
// Bit-plane address former: offset-binary LUT address and plane sign
// for the plane selected by bit_idx of the captured activations.
module da_plane_addr
  import da_pkg::*;
#(
  parameter int DATA_WIDTH_A = 8,
  parameter int K            = 4,
  parameter int IDX_W        = idx_width(DATA_WIDTH_A)
) (
  input  logic [K-1:0][DATA_WIDTH_A-1:0] a,
  input  logic [IDX_W-1:0]               bit_idx,
  output logic [K-2:0]                   addr,
  output logic                           sign_pos
);

  logic         b0_s;
  logic [K-2:0] addr_s;

  // Address bit k-1 is set when activation k agrees with activation 0 on this plane.
  always_comb begin
    b0_s   = a[0][bit_idx];
    addr_s = {(K-1){1'b0}};
    for (int k = 1; k < K; k++) begin
      addr_s[k-1] = ~(a[k][bit_idx] ^ b0_s);
    end
  end

  assign addr     = addr_s;
  assign sign_pos = b0_s;

endmodule

// File: rtl/da_lut_sequencer.sv
// Distributed-arithmetic dot-product sequencer: walks the activation
// bit-planes MSB first, drives an external weight LUT, accumulates its
// output and applies the offset-binary correction before presenting a result.
module da_lut_sequencer
  import da_pkg::*;
#(
  parameter int DATA_WIDTH_A = 8,
  parameter int DATA_WIDTH_B = 8,
  parameter int K            = 4,
  parameter int LUT_WIDTH    = lut_width(DATA_WIDTH_B, K),
  parameter int ACC_WIDTH    = acc_width(LUT_WIDTH, DATA_WIDTH_A)
) (
  input  logic                           clk,
  input  logic                           rst,
  da_lut_sequencer_if.slave              bus,
  output logic                           gen_done,
  output logic [K-2:0]                   addr_array,
  output logic [K-1:0][DATA_WIDTH_B-1:0] B_temp,
  input  logic signed [LUT_WIDTH:0]      LUT_out,
  output logic                           busy
);

  localparam int IDX_W   = idx_width(DATA_WIDTH_A);
  localparam int LUT_EXT = ACC_WIDTH - LUT_WIDTH - 1;
  localparam int B_EXT   = ACC_WIDTH - DATA_WIDTH_B;

  localparam logic [IDX_W-1:0]            LAST_IDX = IDX_W'(DATA_WIDTH_A - 1);
  localparam logic [IDX_W-1:0]            IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]            IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};

  state_e state_r;
  state_e next_state_s;

  logic in_ready_s;
  logic gen_done_s;
  logic busy_s;
  logic accept_s;
  logic run_s;
  logic fix_s;
  logic release_s;

  logic [K-1:0][DATA_WIDTH_A-1:0] a_r;
  logic [K-1:0][DATA_WIDTH_B-1:0] b_r;
  logic signed [ACC_WIDTH-1:0]    acc_r;
  logic [IDX_W-1:0]               bit_idx_r;
  logic signed [ACC_WIDTH-1:0]    result_r;
  logic                           out_valid_r;

  logic [K-2:0]                   plane_addr_s;
  logic                           sign_pos_s;
  logic                           add_term_s;
  logic signed [ACC_WIDTH-1:0]    lut_ext_s;
  logic signed [ACC_WIDTH-1:0]    term_s;
  logic signed [ACC_WIDTH-1:0]    acc_next_s;
  logic signed [ACC_WIDTH-1:0]    q_sum_s;

  da_plane_addr #(
    .DATA_WIDTH_A (DATA_WIDTH_A),
    .K            (K),
    .IDX_W        (IDX_W)
  ) u_plane_addr (
    .a        (a_r),
    .bit_idx  (bit_idx_r),
    .addr     (plane_addr_s),
    .sign_pos (sign_pos_s)
  );

  // FSM state register; reset forces IDLE from any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state: IDLE -> RUN on accept, N planes, one fix-up cycle, then hold until taken.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bit_idx_r == IDX_ZERO) begin
          next_state_s = ST_FIX;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_FIX: begin
        next_state_s = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs and per-state datapath enables; handshakes only count in their own state.
  always_comb begin
    in_ready_s = 1'b0;
    gen_done_s = 1'b0;
    busy_s     = 1'b0;
    accept_s   = 1'b0;
    run_s      = 1'b0;
    fix_s      = 1'b0;
    release_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready_s = 1'b1;
        accept_s   = bus.in_valid;
      end
      ST_RUN: begin
        gen_done_s = 1'b1;
        busy_s     = 1'b1;
        run_s      = 1'b1;
      end
      ST_FIX: begin
        busy_s = 1'b1;
        fix_s  = 1'b1;
      end
      ST_DONE: begin
        busy_s    = 1'b1;
        release_s = bus.out_ready;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // Plane term: LUT value sign-extended, negated when the plane sign and MSB weighting disagree.
  always_comb begin
    lut_ext_s  = {{LUT_EXT{LUT_out[LUT_WIDTH]}}, LUT_out};
    add_term_s = sign_pos_s ^ (bit_idx_r == LAST_IDX);
    if (add_term_s) begin
      term_s = lut_ext_s;
    end else begin
      term_s = -lut_ext_s;
    end
    acc_next_s = (acc_r <<< 1) + term_s;
  end

  // Offset-binary correction: sum of halved weights, each sign-extended to the accumulator.
  always_comb begin
    q_sum_s = ACC_ZERO;
    for (int k = 0; k < K; k++) begin
      q_sum_s = q_sum_s + ($signed({{B_EXT{b_r[k][DATA_WIDTH_B-1]}}, b_r[k]}) >>> 1);
    end
  end

  // Operand capture, plane accumulation and bit-plane index countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r       <= {(K*DATA_WIDTH_A){1'b0}};
      b_r       <= {(K*DATA_WIDTH_B){1'b0}};
      acc_r     <= ACC_ZERO;
      bit_idx_r <= IDX_ZERO;
    end else if (accept_s) begin
      a_r       <= bus.A_in;
      b_r       <= bus.B_in;
      acc_r     <= ACC_ZERO;
      bit_idx_r <= LAST_IDX;
    end else if (run_s) begin
      acc_r <= acc_next_s;
      if (bit_idx_r != IDX_ZERO) begin
        bit_idx_r <= bit_idx_r - IDX_ONE;
      end else begin
        bit_idx_r <= IDX_ZERO;
      end
    end
  end

  // Result register and valid flag: loaded in FIX, held until the consumer takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_r    <= ACC_ZERO;
      out_valid_r <= 1'b0;
    end else if (fix_s) begin
      result_r    <= acc_r - q_sum_s;
      out_valid_r <= 1'b1;
    end else if (release_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign gen_done      = gen_done_s;
  assign addr_array    = gen_done_s ? plane_addr_s : {(K-1){1'b0}};
  assign B_temp        = b_r;
  assign busy          = busy_s;

endmodule

// File: tb/tb_da_lut_sequencer.sv
// Self-checking bench for da_lut_sequencer with a behavioural LUT and a
// dot-product reference computed directly from the operands.
module tb_da_lut_sequencer;

  localparam int DWA = 8;
  localparam int DWB = 8;
  localparam int K   = 4;
  localparam int LW  = DWB + $clog2(K);
  localparam int AW  = LW + DWA + 2;
  localparam int N   = DWA;

  typedef logic [K-1:0][7:0] vec_t;

  logic                  clk;
  logic                  rst;
  logic                  gen_done;
  logic [K-2:0]          addr_array;
  logic [K-1:0][DWB-1:0] B_temp;
  logic signed [LW:0]    lut_out;
  logic                  busy;

  int checks;
  int failures;
  int lut_sum;
  int lut_h;

  da_lut_sequencer_if #(.DATA_WIDTH_A(DWA), .DATA_WIDTH_B(DWB), .K(K), .ACC_WIDTH(AW)) bus ();

  da_lut_sequencer #(
    .DATA_WIDTH_A (DWA),
    .DATA_WIDTH_B (DWB),
    .K            (K),
    .LUT_WIDTH    (LW),
    .ACC_WIDTH    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .gen_done   (gen_done),
    .addr_array (addr_array),
    .B_temp     (B_temp),
    .LUT_out    (lut_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External LUT: halved weight 0 plus halved weights 1..K-1 added or subtracted by address bit.
  always_comb begin
    lut_sum = int'($signed(B_temp[0])) >>> 1;
    for (int k = 1; k < K; k++) begin
      lut_h = int'($signed(B_temp[k])) >>> 1;
      if (addr_array[k-1]) lut_sum = lut_sum + lut_h;
      else                 lut_sum = lut_sum - lut_h;
    end
    lut_out = lut_sum[LW:0];
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic vec_t p4(input int x0, input int x1, input int x2, input int x3);
    vec_t r;
    r[0] = x0[7:0];
    r[1] = x1[7:0];
    r[2] = x2[7:0];
    r[3] = x3[7:0];
    return r;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t r;
    for (int k = 0; k < K; k++) r[k] = 8'($urandom);
    return r;
  endfunction

  // Reference: sum of A[k] * 2 * (B[k] >>> 1) in plain integer arithmetic.
  function automatic longint model(input vec_t a, input vec_t b);
    longint s;
    s = 0;
    for (int k = 0; k < K; k++)
      s += longint'($signed(a[k])) * 2 * (longint'($signed(b[k])) >>> 1);
    return s;
  endfunction

  // Expected address of the MSB plane: activation k's sign bit XNOR activation 0's sign bit.
  function automatic longint msb_addr(input vec_t a);
    logic [K-2:0] r;
    for (int k = 1; k < K; k++) r[k-1] = ~(a[k][DWA-1] ^ a[0][DWA-1]);
    return longint'(r);
  endfunction

  // One operation from an IDLE negedge through the result handshake back to IDLE.
  task automatic do_op(input vec_t a, input vec_t b, input int hold, input bit chain,
                       input vec_t na, input vec_t nb);
    longint exp_v;
    int     edges;
    int     gd;
    exp_v = model(a, b);
    check("in_ready_idle", longint'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.A_in     = a;
    bus.B_in     = b;
    @(posedge clk);
    @(negedge clk);
    check("addr_msb_plane", longint'(addr_array), msb_addr(a));
    check("b_temp_run", longint'(B_temp), longint'(b));
    edges = 0;
    gd    = 0;
    while (bus.out_valid !== 1'b1 && edges < 40) begin
      gd = gd + int'(gen_done);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.A_in      = rnd_vec();
      bus.B_in      = rnd_vec();
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    check("latency_edges", edges, N + 1);
    check("gen_done_cycles", gd, N);
    check("result", longint'($signed(bus.result)), exp_v);
    check("in_ready_done", longint'(bus.in_ready), 0);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.A_in     = rnd_vec();
      bus.B_in     = rnd_vec();
      @(posedge clk);
      @(negedge clk);
      check("hold_result", longint'($signed(bus.result)), exp_v);
      check("hold_out_valid", longint'(bus.out_valid), 1);
      check("hold_in_ready", longint'(bus.in_ready), 0);
      check("hold_b_temp", longint'(B_temp), longint'(b));
      check("hold_gen_done", longint'(gen_done), 0);
    end
    bus.out_ready = 1'b1;
    if (chain) begin
      bus.in_valid = 1'b1;
      bus.A_in     = na;
      bus.B_in     = nb;
    end else begin
      bus.in_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_out_valid", longint'(bus.out_valid), 0);
    check("post_in_ready", longint'(bus.in_ready), 1);
    check("post_busy", longint'(busy), 0);
  endtask

  initial begin
    vec_t ra;
    vec_t rb;
    vec_t za;
    checks        = 0;
    failures      = 0;
    za            = p4(0, 0, 0, 0);
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A_in      = za;
    bus.B_in      = za;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", longint'(bus.in_ready), 1);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_result", longint'($signed(bus.result)), 0);
    check("rst_gen_done", longint'(gen_done), 0);
    check("rst_addr", longint'(addr_array), 0);
    check("rst_b_temp", longint'(B_temp), 0);
    check("rst_busy", longint'(busy), 0);
    rst = 1'b1;

    // Directed vectors, first one accepted on the first edge after release
    do_op(p4(1, 0, 0, 0), p4(4, 6, 8, 10), 0, 1'b0, za, za);
    do_op(p4(-128, 127, 1, -1), p4(2, 2, 2, 2), 0, 1'b0, za, za);
    do_op(p4(1, 1, 1, 1), p4(3, -3, 5, 7), 5, 1'b0, za, za);
    do_op(p4(-128, -128, -128, -128), p4(-128, -128, -128, -128), 1, 1'b0, za, za);
    do_op(p4(127, 127, 127, 127), p4(127, 127, 127, 127), 0, 1'b0, za, za);

    // Back-to-back: next operands held valid across the handshake edge
    ra = rnd_vec();
    rb = rnd_vec();
    do_op(p4(-5, 17, 100, -77), p4(9, -14, 33, 64), 2, 1'b1, ra, rb);
    do_op(ra, rb, 0, 1'b0, za, za);

    // Randomized operations with random result back-pressure
    for (int i = 0; i < 20; i++) begin
      do_op(rnd_vec(), rnd_vec(), int'($urandom_range(0, 3)), 1'b0, za, za);
    end

    // Reset asserted in the 4th RUN cycle, then a fresh operation
    bus.in_valid = 1'b1;
    bus.A_in     = rnd_vec();
    bus.B_in     = p4(11, 22, 33, 44);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_run_gen_done", longint'(gen_done), 1);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_gen_done", longint'(gen_done), 0);
    check("mrst_addr", longint'(addr_array), 0);
    check("mrst_out_valid", longint'(bus.out_valid), 0);
    check("mrst_result", longint'($signed(bus.result)), 0);
    check("mrst_b_temp", longint'(B_temp), 0);
    check("mrst_busy", longint'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    do_op(p4(2, 0, 0, 0), p4(6, 0, 0, 0), 0, 1'b0, za, za);
    check("after_rst_result_value", longint'($signed(bus.result)), 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
